addsub_rr_scheduler: RTL and testbench

- Shares one `adder_subtractor` datapath instance among NUM_REQ requesters using round-robin arbitration.
- Each requester issues an (a, b, sub) operation over a valid/ready handshake.
- The block latches the winning operands, drives the shared datapath, registers the result and returns it with the requester ID on a valid/ready response channel.
- Sits between the client blocks and the single arithmetic resource.

---
 rtl/addsub_sched_pkg.sv | 9 +
 rtl/adder_subtractor.sv | 35 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/addsub_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_addsub_rr_scheduler.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_sched_pkg.sv
// Shared types and default widths for the round-robin add/sub scheduler.
package addsub_sched_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} sched_state_e;

    localparam int unsigned DEF_N       = 4;
    localparam int unsigned DEF_NUM_REQ = 4;

endpackage

// File: rtl/adder_subtractor.sv
// N-bit adder/subtractor: sum = a + (b ^ {N{sub}}) + sub, modulo 2^N.
// Optional signed-overflow output under ADDSUB_SCHED_OVF_EN.
module adder_subtractor
    import addsub_sched_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef ADDSUB_SCHED_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic [N-1:0] b_eff;
    logic [N:0]   full;

    assign b_eff = b ^ {N{sub}};
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};
    assign sum   = full[N-1:0];
    assign cout  = full[N];

`ifdef ADDSUB_SCHED_OVF_EN
    // Carry into the MSB comes from adding the lower N-1 bits alone.
    logic [N-1:0] low;

    assign low = {1'b0, a[N-2:0]} + {1'b0, b_eff[N-2:0]} + {{(N-1){1'b0}}, sub};
    assign ovf = low[N-1] ^ full[N];
`endif

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping around to index 0.
module rr_arbiter
    import addsub_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               any_grant
);

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        int unsigned idx;
        logic [ID_W-1:0] idx_w;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx   = (32'(ptr) + i) % NUM_REQ;
            idx_w = ID_W'(idx);
            if (!any_grant && req[idx_w]) begin
                grant[idx_w] = 1'b1;
                grant_idx    = idx_w;
                any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one adder_subtractor among NUM_REQ requesters.
// Optional feature macro: ADDSUB_SCHED_OVF_EN adds registered rsp_ovf_o.
module addsub_rr_scheduler
    import addsub_sched_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [NUM_REQ*N-1:0] req_a_i,
    input  logic [NUM_REQ*N-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]   req_sub_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [N-1:0]         rsp_data_o,
    output logic                 rsp_cout_o,
    output logic [ID_W-1:0]      rsp_id_o
`ifdef ADDSUB_SCHED_OVF_EN
    ,
    output logic                 rsp_ovf_o
`endif
);

    sched_state_e state, state_nxt;

    logic [ID_W-1:0]    rr_ptr;
    logic [N-1:0]       a_q, b_q;
    logic               sub_q;
    logic [ID_W-1:0]    id_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic               accept;

    logic [N-1:0]       sel_a, sel_b;
    logic               sel_sub;

    logic [N-1:0]       sum;
    logic               cout;
`ifdef ADDSUB_SCHED_OVF_EN
    logic               ovf;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    adder_subtractor #(
        .N (N)
    ) u_addsub (
        .a    (a_q),
        .b    (b_q),
        .sub  (sub_q),
        .sum  (sum),
        .cout (cout)
`ifdef ADDSUB_SCHED_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    // Ready is gated by rst_ni so it reads 0 while reset is asserted, even
    // with requesters valid.
    assign req_ready_o = (state == IDLE && rst_ni) ? grant : '0;
    assign accept      = (state == IDLE) && any_grant;

    // Operand mux for the winning requester.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_a   = req_a_i[k*N +: N];
                sel_b   = req_b_i[k*N +: N];
                sel_sub = req_sub_i[k];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)      state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP: if (rsp_ready_i) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand capture, pointer advance and result registration.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            id_q        <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_cout_o  <= 1'b0;
            rsp_id_o    <= '0;
`ifdef ADDSUB_SCHED_OVF_EN
            rsp_ovf_o   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= sel_a;
                        b_q   <= sel_b;
                        sub_q <= sel_sub;
                        id_q  <= grant_idx;
                        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_idx + 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data_o  <= sum;
                    rsp_cout_o  <= cout;
                    rsp_id_o    <= id_q;
                    rsp_valid_o <= 1'b1;
`ifdef ADDSUB_SCHED_OVF_EN
                    rsp_ovf_o   <= ovf;
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Self-checking bench for addsub_rr_scheduler (N=4, NUM_REQ=4).
module tb_addsub_rr_scheduler;

    localparam int N       = 4;
    localparam int NUM_REQ = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [NUM_REQ-1:0]   req_valid_i;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic [NUM_REQ*N-1:0] req_a_i;
    logic [NUM_REQ*N-1:0] req_b_i;
    logic [NUM_REQ-1:0]   req_sub_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [N-1:0]         rsp_data_o;
    logic                 rsp_cout_o;
    logic [1:0]           rsp_id_o;
`ifdef ADDSUB_SCHED_OVF_EN
    logic                 rsp_ovf_o;
`endif

    addsub_rr_scheduler #(
        .N       (N),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_sub_i   (req_sub_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_cout_o  (rsp_cout_o),
        .rsp_id_o    (rsp_id_o)
`ifdef ADDSUB_SCHED_OVF_EN
        ,
        .rsp_ovf_o   (rsp_ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned req;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        sub;
        logic [3:0]  data;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [3:0] data;
        logic       cout;
        logic [1:0] id;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_pt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_pt();
        @(negedge clk_i);
    endtask

    // Response monitor: compares each completed response handshake against the scoreboard.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni === 1'b1 && rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got response id %0d, required none", rsp_id_o);
            end else begin
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data_o), 32'(e.data));
                check("rsp_cout", 32'(rsp_cout_o), 32'(e.cout));
                check("rsp_id",   32'(rsp_id_o),   32'(e.id));
`ifdef ADDSUB_SCHED_OVF_EN
                check("rsp_ovf",  32'(rsp_ovf_o),  32'(e.ovf));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int unsigned k;

        //          req a      b      sub   data   cout  ovf
        vecs[0] = '{0, 4'd5,  4'd3,  1'b1, 4'd2,  1'b1, 1'b0};
        vecs[1] = '{2, 4'd3,  4'd5,  1'b1, 4'd14, 1'b0, 1'b0};
        vecs[2] = '{1, 4'd9,  4'd8,  1'b0, 4'd1,  1'b1, 1'b1};
        vecs[3] = '{3, 4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0};
        vecs[4] = '{0, 4'd0,  4'd1,  1'b1, 4'd15, 1'b0, 1'b0};
        vecs[5] = '{1, 4'd7,  4'd7,  1'b1, 4'd0,  1'b1, 1'b0};
        vecs[6] = '{2, 4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1};

        rst_ni      = 1'b0;
        req_valid_i = 4'b0001;
        req_a_i     = '0;
        req_b_i     = '0;
        req_sub_i   = '0;
        rsp_ready_i = 1'b1;

        // Reset state, with a requester valid during reset.
        check_pt();
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_data",  32'(rsp_data_o),  32'd0);
        check("rst_cout",  32'(rsp_cout_o),  32'd0);
        check("rst_id",    32'(rsp_id_o),    32'd0);
        drive_pt();
        rst_ni      = 1'b1;
        req_valid_i = '0;

        // Table-driven single-requester operations.
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            req_valid_i        = '0;
            req_valid_i[v.req] = 1'b1;
            req_a_i[v.req*N +: N] = v.a;
            req_b_i[v.req*N +: N] = v.b;
            req_sub_i[v.req]      = v.sub;
            sb.push_back('{v.data, v.cout, 2'(v.req), v.ovf});
            check_pt();
            check("vec_grant", 32'(req_ready_o), 32'(1 << v.req));
            drive_pt();
            req_valid_i = '0;
            check_pt();
            check("vec_exec_ready", 32'(req_ready_o), 32'd0);
            check("vec_exec_valid", 32'(rsp_valid_o), 32'd0);
            drive_pt();
            check_pt();
            check("vec_resp_valid", 32'(rsp_valid_o), 32'd1);
            check("vec_resp_ready", 32'(req_ready_o), 32'd0);
            drive_pt();
        end

        // Return rr_ptr to 0, then all requesters valid continuously.
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_a_i[r*N +: N] = 4'(r + 1);
            req_b_i[r*N +: N] = 4'(r);
            req_sub_i[r]      = 1'b0;
        end
        req_valid_i = '1;
        for (int g = 0; g < 5; g++) begin
            k = g % NUM_REQ;
            sb.push_back('{4'(2 * k + 1), 1'b0, 2'(k), 1'b0});
            check_pt();
            check("rr_grant", 32'(req_ready_o), 32'(1 << k));
            drive_pt();
            if (g == 4) req_valid_i = '0;
            check_pt();
            check("rr_exec_ready", 32'(req_ready_o), 32'd0);
            drive_pt();
            check_pt();
            check("rr_resp_ready", 32'(req_ready_o), 32'd0);
            check("rr_resp_valid", 32'(rsp_valid_o), 32'd1);
            drive_pt();
        end

        // Back-pressure: response held while rsp_ready_i is low, req0 waits.
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0010;
        req_a_i[1*N +: N] = 4'd9;
        req_b_i[1*N +: N] = 4'd8;
        req_sub_i[1]      = 1'b0;
        check_pt();
        check("hold_grant1", 32'(req_ready_o), 32'b0010);
        drive_pt();
        req_valid_i = 4'b0001;
        req_a_i[0*N +: N] = 4'd2;
        req_b_i[0*N +: N] = 4'd2;
        req_sub_i[0]      = 1'b0;
        check_pt();
        check("hold_exec_ready", 32'(req_ready_o), 32'd0);
        drive_pt();
        for (int c = 0; c < 5; c++) begin
            check_pt();
            check("hold_valid", 32'(rsp_valid_o), 32'd1);
            check("hold_data",  32'(rsp_data_o),  32'd1);
            check("hold_cout",  32'(rsp_cout_o),  32'd1);
            check("hold_id",    32'(rsp_id_o),    32'd1);
            check("hold_ready", 32'(req_ready_o), 32'd0);
            drive_pt();
        end
        sb.push_back('{4'd1, 1'b1, 2'd1, 1'b1});
        rsp_ready_i = 1'b1;
        check_pt();
        check("hold_release_ready", 32'(req_ready_o), 32'd0);
        drive_pt();
        sb.push_back('{4'd4, 1'b0, 2'd0, 1'b0});
        check_pt();
        check("hold_next_grant", 32'(req_ready_o), 32'b0001);
        drive_pt();
        req_valid_i = '0;
        check_pt();
        drive_pt();
        check_pt();
        drive_pt();

        // Asynchronous reset while in RESP discards the in-flight result.
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b1000;
        req_a_i[3*N +: N] = 4'd6;
        req_b_i[3*N +: N] = 4'd3;
        req_sub_i[3]      = 1'b0;
        check_pt();
        check("rst_test_grant", 32'(req_ready_o), 32'b1000);
        drive_pt();
        req_valid_i = '0;
        check_pt();
        drive_pt();
        check_pt();
        check("pre_rst_valid", 32'(rsp_valid_o), 32'd1);
        check("pre_rst_data",  32'(rsp_data_o),  32'd9);
        drive_pt();
        req_valid_i = 4'b1010;
        req_a_i[1*N +: N] = 4'd4;
        req_b_i[1*N +: N] = 4'd1;
        req_sub_i[1]      = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("async_rst_data",  32'(rsp_data_o),  32'd0);
        check("async_rst_id",    32'(rsp_id_o),    32'd0);
        check("async_rst_cout",  32'(rsp_cout_o),  32'd0);
        check("async_rst_ready", 32'(req_ready_o), 32'd0);
`ifdef ADDSUB_SCHED_OVF_EN
        check("async_rst_ovf",   32'(rsp_ovf_o),   32'd0);
`endif
        rsp_ready_i = 1'b1;
        #1;
        rst_ni = 1'b1;
        sb.push_back('{4'd3, 1'b1, 2'd1, 1'b0});
        check_pt();
        check("post_rst_valid", 32'(rsp_valid_o), 32'd0);
        check("post_rst_grant", 32'(req_ready_o), 32'b0010);
        drive_pt();
        req_valid_i = '0;
        check_pt();
        drive_pt();
        check_pt();
        drive_pt();
        check_pt();

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
